// File: rtl/vga_timing_controller_if.sv
// Line-buffer fetch channel: one request per active line, acknowledged by a 1-clk pulse.
// The controller owns the request side; the line buffer answers with line_ack.
interface vga_timing_controller_if;
    logic       line_req;
    logic       line_ack;
    logic [9:0] line_num;
    logic       underrun;

    modport master (output line_req, output line_num, output underrun, input line_ack);
    modport slave  (input line_req, input line_num, input underrun, output line_ack);
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel counters, registered sync/video decode, and a
// one-fetch-per-line request schedule with deadline/underrun reporting.
module vga_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pix_en,
    input  logic                           enable,
    vga_timing_controller_if.master        fetch,
    output logic [9:0]                     pixel_x,
    output logic [9:0]                     pixel_y,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           video_on,
    output logic                           frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] H_FETCH = 10'(H_ACTIVE - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] num_q, num_d;
    logic       req_q, req_d, und_q, und_d, fs_q, fs_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
    logic       x_wrap, y_last, scanning_d;
    logic [9:0] y_next;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        req_d   = req_q;
        num_d   = num_q;
        und_d   = 1'b0;
        fs_d    = 1'b0;
        x_wrap  = (x_q == H_MAX);
        y_last  = (y_q == V_MAX);
        y_next  = y_last ? 10'd0 : y_q + 10'd1;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                    req_d   = 1'b1;
                    num_d   = 10'd0;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (fetch.line_ack) begin
                    state_d = RUN;
                    req_d   = 1'b0;
                    fs_d    = 1'b1;
                end
            end
            default: begin
                // An ack landing on the deadline edge still counts as delivered.
                if (req_q && fetch.line_ack) begin
                    req_d = 1'b0;
                end else if (req_q && pix_en && x_wrap) begin
                    req_d = 1'b0;
                    und_d = 1'b1;
                end
                if (pix_en) begin
                    x_d = x_wrap ? 10'd0 : x_q + 10'd1;
                    if (x_wrap) y_d = y_next;
                    if (state_q == RUN && x_q == H_FETCH && y_next < V_ACT) begin
                        req_d = 1'b1;
                        num_d = y_next;
                    end
                    if (x_wrap && y_last) begin
                        if (state_q == DRAIN) state_d = IDLE;
                        else                  fs_d    = 1'b1;
                    end
                end
                if (state_q == RUN && !enable) state_d = DRAIN;
            end
        endcase

        // Decode the count being loaded so the syncs line up with pixel_x/pixel_y.
        scanning_d = (state_d == RUN) || (state_d == DRAIN);
        hsync_d    = ~SYNC_POL;
        vsync_d    = ~SYNC_POL;
        if (scanning_d && x_d >= HS_BEG && x_d < HS_END) hsync_d = SYNC_POL;
        if (scanning_d && y_d >= VS_BEG && y_d < VS_END) vsync_d = SYNC_POL;
        video_d = (state_d == RUN) && (x_d < H_ACT) && (y_d < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            num_q   <= '0;
            und_q   <= 1'b0;
            fs_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            req_q   <= req_d;
            num_q   <= num_d;
            und_q   <= und_d;
            fs_q    <= fs_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    assign pixel_x        = x_q;
    assign pixel_y        = y_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign video_on       = video_q;
    assign frame_start    = fs_q;
    assign fetch.line_req = req_q;
    assign fetch.line_num = num_q;
    assign fetch.underrun = und_q;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Random-stimulus bench for vga_timing_controller on a shrunken raster, checked
// every clock against a linear-pixel-index reference model.
module tb_vga_timing_controller;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit POL = 1'b0;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DRAIN = 3;

    logic       clk = 1'b0;
    logic       reset, pix_en, enable;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync, vsync, video_on, frame_start;

    vga_timing_controller_if fetch ();

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable), .fetch(fetch),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int mode = M_IDLE, pos = 0, num = 0;
    bit req = 0, und = 0, fs = 0;
    int n_fs = 0, n_und = 0, n_stop = 0, n_ackdead = 0;
    bit cur_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: mode plus a linear pixel index into the frame.
    task automatic model_step(input bit rst, input bit en, input bit ack, input bit pe);
        int x, y, n, old;
        fs  = 0;
        und = 0;
        if (rst) begin
            mode = M_IDLE; pos = 0; req = 0; num = 0;
            return;
        end
        old = mode;
        x   = pos % HT;
        y   = pos / HT;
        if (old == M_IDLE) begin
            if (en) begin mode = M_PRIME; req = 1; num = 0; end
        end else if (old == M_PRIME) begin
            if (!en) begin mode = M_IDLE; req = 0; end
            else if (ack) begin mode = M_RUN; req = 0; fs = 1; end
        end else begin
            if (req && ack) begin
                if (pe && x == HT - 1) n_ackdead++;
                req = 0;
            end else if (req && pe && x == HT - 1) begin
                req = 0; und = 1;
            end
            if (pe) begin
                if (old == M_RUN && x == HA - 1) begin
                    n = (y + 1) % VT;
                    if (n < VA) begin req = 1; num = n; end
                end
                pos = (pos + 1) % (HT * VT);
                if (pos == 0) begin
                    if (old == M_DRAIN) begin mode = M_IDLE; n_stop++; end
                    else fs = 1;
                end
            end
            if (old == M_RUN && !en) mode = M_DRAIN;
        end
        if (fs)  n_fs++;
        if (und) n_und++;
    endtask

    task automatic check_all();
        int x, y;
        bit act;
        x   = pos % HT;
        y   = pos / HT;
        act = (mode == M_RUN) || (mode == M_DRAIN);
        chk("pixel_x", pixel_x, x);
        chk("pixel_y", pixel_y, y);
        chk("hsync", hsync, (act && x >= HA + HF && x < HA + HF + HS) ? POL : !POL);
        chk("vsync", vsync, (act && y >= VA + VF && y < VA + VF + VS) ? POL : !POL);
        chk("video_on", video_on, (mode == M_RUN && x < HA && y < VA));
        chk("frame_start", frame_start, fs);
        chk("line_req", fetch.line_req, req);
        chk("line_num", fetch.line_num, num);
        chk("underrun", fetch.underrun, und);
    endtask

    task automatic cycle(input bit rst, input bit en, input bit ack, input bit pe);
        @(negedge clk);
        reset = rst; enable = en; fetch.line_ack = ack; pix_en = pe;
        model_step(rst, en, ack, pe);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Random ack: usually answers a pending request, sometimes right on the deadline,
    // occasionally strays while nothing is pending.
    task automatic rand_cycle(input bit rst, input bit en, input bit pe);
        bit ack;
        if (req) begin
            if (pe && (pos % HT) == HT - 1 && mode >= M_RUN) ack = ($urandom_range(0, 1) == 0);
            else ack = ($urandom_range(0, 9) == 0);
        end else begin
            ack = ($urandom_range(0, 15) == 0);
        end
        cycle(rst, en, ack, pe);
    endtask

    initial begin
        reset = 1; enable = 0; pix_en = 0; fetch.line_ack = 0;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1'($urandom_range(0, 1)));

        // Prime: request line 0, ack two clocks later.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 3 * HT * VT * 2; i++) rand_cycle(0, 1, 1'(i % 2));

        for (int i = 0; i < 3000; i++) rand_cycle(0, 1, ($urandom_range(0, 9) < 6));

        // Stop request; enable bounces during drain.
        for (int i = 0; i < 1500; i++) rand_cycle(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));

        for (int i = 0; i < 700; i++) rand_cycle(0, 1, ($urandom_range(0, 9) < 7));
        cycle(1, 1, 0, 1);
        for (int i = 0; i < 200; i++) rand_cycle(0, 1, ($urandom_range(0, 9) < 7));

        cur_en = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 299) == 0) cur_en = !cur_en;
            rand_cycle(($urandom_range(0, 2999) == 0), cur_en, ($urandom_range(0, 9) < 7));
        end

        chk("cov_frame_start", (n_fs > 0), 1);
        chk("cov_underrun", (n_und > 0), 1);
        chk("cov_drain_stop", (n_stop > 0), 1);
        chk("cov_ack_on_deadline", (n_ackdead > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
